// File: rtl/instr_load_pkg.sv
// Shared framing constants and transmitter FSM states for the instruction-memory byte-load link.
package instr_load_pkg;

  localparam logic [7:0] START_MARK = 8'hFE;
  localparam logic [7:0] END_MARK   = 8'hFF;
  localparam logic [7:0] PAD_BYTE   = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_BYTES = 3'd3,
    ST_END   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/instr_stream_tx.sv
// Streams N source-RAM words as FE, payload bytes MSB-first, FF: one byte per clock, no bubbles.
// Outputs are decoded from registered state only; start_i is ignored while a stream is in flight.
module instr_stream_tx
  import instr_load_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_words_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              clip_o
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  tx_state_t         state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        b_idx;
  logic [31:0]       shift;
  logic              done_q;
  logic              clip_q;
  logic              last_word;
  logic [7:0]        top_byte;

  assign top_byte  = shift[31:24];
  assign last_word = (({1'b0, w_idx}) + (ADDR_W+1)'(1)) == n_words;
  assign done_o    = done_q;
  assign clip_o    = clip_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      n_words <= '0;
      w_idx   <= '0;
      b_idx   <= '0;
      shift   <= '0;
      done_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            n_words <= (num_words_i > DEPTH_W) ? DEPTH_W : num_words_i;
            clip_q  <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_START;
        ST_START: begin
          shift <= rd_data_i;
          w_idx <= '0;
          b_idx <= '0;
          state <= (n_words == '0) ? ST_END : ST_BYTES;
        end
        ST_BYTES: begin
          if (top_byte == END_MARK) clip_q <= 1'b1;
          b_idx <= b_idx + 2'd1;
          shift <= {shift[23:0], 8'h00};
          // The next word was fetched at b=2, so its data is on rd_data_i now.
          if (b_idx == 2'd3) begin
            if (last_word) begin
              state <= ST_END;
            end else begin
              w_idx <= w_idx + ADDR_W'(1);
              shift <= rd_data_i;
            end
          end
        end
        ST_END: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_o       = PAD_BYTE;
    byte_valid_o = 1'b0;
    busy_o       = 1'b0;
    rd_en_o      = 1'b0;
    rd_addr_o    = '0;
    case (state)
      ST_FETCH: begin
        busy_o  = 1'b1;
        rd_en_o = 1'b1;
      end
      ST_START: begin
        busy_o       = 1'b1;
        byte_valid_o = 1'b1;
        byte_o       = START_MARK;
      end
      ST_BYTES: begin
        busy_o       = 1'b1;
        byte_valid_o = 1'b1;
        byte_o       = (top_byte == END_MARK) ? PAD_BYTE : top_byte;
        if (b_idx == 2'd2 && !last_word) begin
          rd_en_o   = 1'b1;
          rd_addr_o = w_idx + ADDR_W'(1);
        end
      end
      ST_END: begin
        busy_o       = 1'b1;
        byte_valid_o = 1'b1;
        byte_o       = END_MARK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_stream_tx.sv
// Bench for instr_stream_tx: cycle-indexed stream model, source RAM model and receiving instruction memory.
module tb_instr_stream_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [6:0]  num_words_i;
  logic        rd_en_o;
  logic [5:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o, busy_o, done_o, clip_o;

  instr_stream_tx #(.ADDR_W(6), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .num_words_i(num_words_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .busy_o(busy_o),
    .done_o(done_o), .clip_o(clip_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source RAM: one-cycle latency, garbage when not read so mistimed captures show up.
  logic [31:0] mem [0:63];
  always @(posedge clk) rd_data_i <= rd_en_o ? mem[rd_addr_o] : 32'hA5C3_5A3C;

  // Stream model: expected byte sequence and start cycle of the stream in flight.
  logic [7:0] eb [0:257];
  logic       ef [0:257];
  bit         m_active = 0;
  int         m_k, m_n;
  bit         clip_m = 0;
  logic [7:0] got [$];
  int         rd_cnt, last_addr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int rel;
    logic ev, ebusy, edone, erd;
    logic [7:0] ebyte;
    int eaddr;
    if (reset) begin
      chk("rst_byte", 32'(byte_o), 32'h0);
      chk("rst_valid", 32'(byte_valid_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_done", 32'(done_o), 32'h0);
      chk("rst_clip", 32'(clip_o), 32'h0);
      chk("rst_rd_en", 32'(rd_en_o), 32'h0);
      chk("rst_rd_addr", 32'(rd_addr_o), 32'h0);
    end else begin
      rel = -1; ev = 0; ebusy = 0; edone = 0; erd = 0; ebyte = 8'h00; eaddr = 0;
      if (m_active) begin
        rel = cyc - m_k;
        if (rel == 1) clip_m = 0;
        ebusy = (rel >= 1) && (rel <= 3 + 4*m_n);
        ev    = (rel >= 2) && (rel <= 3 + 4*m_n);
        if (ev) ebyte = eb[rel-2];
        edone = (rel == 4 + 4*m_n);
        erd   = (rel == 1) || (rel >= 5 && ((rel-5) % 4) == 0 && ((rel-5)/4) < m_n-1);
        eaddr = (rel == 1) ? 0 : (rel-5)/4 + 1;
      end
      chk("valid", 32'(byte_valid_o), 32'(ev));
      chk("byte", 32'(byte_o), 32'(ebyte));
      chk("busy", 32'(busy_o), 32'(ebusy));
      chk("done", 32'(done_o), 32'(edone));
      chk("clip", 32'(clip_o), 32'(clip_m));
      chk("rd_en", 32'(rd_en_o), 32'(erd));
      if (erd) chk("rd_addr", 32'(rd_addr_o), 32'(eaddr));
      if (byte_valid_o) got.push_back(byte_o);
      if (rd_en_o) begin rd_cnt++; last_addr = rd_addr_o; end
      if (m_active && ev && rel >= 3 && rel <= 2 + 4*m_n && ef[rel-2]) clip_m = 1;
      if (m_active && rel >= 4 + 4*m_n) m_active = 0;
    end
  end

  // Receiving instruction memory: frames on FE, assembles MSB-first words, closes on FF.
  logic [31:0] imem [0:63];
  bit          framing;
  int          widx, bcnt;
  logic [31:0] asm_w;
  always @(negedge clk) begin
    if (reset) begin
      framing = 0; widx = 0; bcnt = 0;
    end else if (byte_valid_o) begin
      if (!framing && byte_o == 8'hFE) begin
        framing = 1; widx = 0; bcnt = 0;
      end else if (framing && byte_o == 8'hFF) begin
        framing = 0;
      end else if (framing) begin
        asm_w = {asm_w[23:0], byte_o};
        bcnt++;
        if (bcnt == 4) begin imem[widx[5:0]] = asm_w; widx++; bcnt = 0; end
      end
    end
  end

  task automatic begin_stream(input int n);
    @(posedge clk); #1;
    start_i = 1'b1;
    num_words_i = 7'(n);
    m_k = cyc;
    m_n = (n > 64) ? 64 : n;
    eb[0] = 8'hFE; ef[0] = 1'b0;
    for (int w = 0; w < m_n; w++)
      for (int j = 0; j < 4; j++) begin
        logic [7:0] by;
        by = mem[w][31-8*j -: 8];
        ef[1+4*w+j] = (by == 8'hFF);
        eb[1+4*w+j] = (by == 8'hFF) ? 8'h00 : by;
      end
    eb[4*m_n+1] = 8'hFF; ef[4*m_n+1] = 1'b0;
    got.delete();
    rd_cnt = 0;
    m_active = 1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run(input int n, input int ignore_at);
    int budget;
    begin_stream(n);
    budget = 4*n + 40;
    while (m_active && budget > 0) begin
      if (ignore_at > 0 && cyc - m_k == ignore_at) begin start_i = 1'b1; num_words_i = 7'd2; end
      else start_i = 1'b0;
      @(posedge clk); #1;
      budget--;
    end
    start_i = 1'b0;
    if (m_active) begin
      chk("stream_timeout", 32'd1, 32'd0);
      m_active = 0;
    end
  endtask

  task automatic chk_got(input string name, input logic [7:0] exp [$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; num_words_i = 7'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    mem[0] = 32'h12345678;
    run(1, 0);
    chk_got("n1_bytes", '{8'hFE, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF});
    chk("n1_clip", 32'(clip_o), 32'h0);

    mem[0] = 32'hDEADBEEF; mem[1] = 32'h00000013; mem[2] = 32'hCAFEF00D;
    run(3, 0);
    chk("n3_imem0", imem[0], 32'hDEADBEEF);
    chk("n3_imem1", imem[1], 32'h00000013);
    chk("n3_imem2", imem[2], 32'hCAFEF00D);
    chk("n3_len", 32'(got.size()), 32'd14);

    run(0, 0);
    chk_got("n0_bytes", '{8'hFE, 8'hFF});
    chk("n0_rd_pulses", 32'(rd_cnt), 32'd1);

    mem[0] = 32'hFF00FEFF;
    run(1, 0);
    chk_got("clip_bytes", '{8'hFE, 8'h00, 8'h00, 8'hFE, 8'h00, 8'hFF});
    repeat (3) @(posedge clk);
    #1 chk("clip_sticky", 32'(clip_o), 32'h1);
    mem[0] = 32'h01020304;
    run(1, 0);
    chk("clip_cleared", 32'(clip_o), 32'h0);

    for (int i = 0; i < 64; i++) mem[i] = (i * 32'h0103_0507) ^ 32'h10FF_3040;
    run(100, 40);
    chk("clamp_len", 32'(got.size()), 32'd258);
    chk("clamp_last_addr", 32'(last_addr), 32'd63);
    chk("clamp_rd_pulses", 32'(rd_cnt), 32'd64);
    chk("clamp_imem63", imem[63], (63 * 32'h0103_0507) ^ 32'h10FF_3040);

    for (int i = 0; i < 4; i++) mem[i] = 32'h1111_1111 * (i + 1);
    begin_stream(4);
    while (cyc - m_k < 7) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    m_active = 0; clip_m = 0;
    #1 chk("mid_rst_byte", 32'(byte_o), 32'h0);
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    run(4, 0);
    chk("rerun_len", 32'(got.size()), 32'd18);
    for (int i = 0; i < 4; i++) chk("rerun_imem", imem[i], 32'h1111_1111 * (i + 1));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_stream_tx.md
# instr_stream_tx

Byte-serial transmitter that streams a block of 32-bit instruction words into the instruction memory's byte-load port. It reads words from a synchronous source RAM and emits one framed stream: start marker 0xFE, then each word MSB-first, then end marker 0xFF. The output is one byte per clock with no bubbles. It sits between the boot/debug word buffer and the instruction memory load input.

## Interface
- `ADDR_W`, default 6: word address width of the source RAM.
- `DEPTH`, default 64: maximum words per stream; must equal 2**ADDR_W.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  one-cycle request to begin a stream; sampled only in IDLE.
- `num_words_i`  in  ADDR_W+1  words to send; sampled with `start_i`.
- `rd_en_o`  out  1  source RAM read strobe.
- `rd_addr_o`  out  ADDR_W  source RAM word address.
- `rd_data_i`  in  32  source RAM data, valid the cycle after `rd_en_o`.
- `byte_o`  out  8  stream byte; drives the instruction memory byte-load input.
- `byte_valid_o`  out  1  high on every framed byte (marker or payload).
- `busy_o`  out  1  high from the cycle after start acceptance through the 0xFF cycle.
- `done_o`  out  1  one-cycle pulse in the cycle after 0xFF.
- `clip_o`  out  1  sticky: a payload byte of 0xFF was replaced by 0x00; cleared by the next accepted start.

## Operation
- FSM states: IDLE, FETCH, START, BYTES, END.
- IDLE
  - Outputs: `byte_o`=0x00, `byte_valid_o`=0, `busy_o`=0, `rd_en_o`=0.
  - `start_i`=1: latch N = min(`num_words_i`, DEPTH), clear `clip_o`, go to FETCH.
- FETCH (1 cycle): `rd_en_o`=1, `rd_addr_o`=0. Go to START.
- START (1 cycle)
  - `byte_o`=0xFE.
  - Capture `rd_data_i` into the 32-bit shift register at the end of the cycle.
  - Go to BYTES if N>0, else END.
- BYTES
  - 2-bit byte index b and word counter w, both starting at 0.
  - `byte_o` = shift[31:24]; shift left 8 each cycle.
  - A payload byte of 0xFF is sent as 0x00 and sets `clip_o`; the receiver treats 0xFF as end-of-frame.
  - Payload 0xFE is sent unchanged; the receiver is already framing, so it is harmless.
  - At b=2 with w<N-1: `rd_en_o`=1, `rd_addr_o`=w+1.
  - At the end of b=3: load the shift register from `rd_data_i`, increment w.
  - After b=3 of word N-1, go to END.
- END (1 cycle): `byte_o`=0xFF. Go to IDLE and assert `done_o` for the next cycle.
- `start_i` outside IDLE is ignored; it is not queued.
- `num_words_i`=0 gives the 2-byte stream 0xFE, 0xFF.
- Values above DEPTH clamp to DEPTH.
- w counts to N-1 ≤ DEPTH-1, so `rd_addr_o` never wraps.
- `reset` mid-stream returns to IDLE at once with all outputs at reset values.
  - No 0xFF is sent, so the receiver may be left mid-frame.
  - The system must reset the transmitter and the instruction memory together.

## Timing
- Reset values: `byte_o`=0x00, `byte_valid_o`=0, `busy_o`=0, `done_o`=0, `clip_o`=0, `rd_en_o`=0, `rd_addr_o`=0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- `start_i` sampled at edge k:
  - FETCH in cycle k+1.
  - 0xFE in cycle k+2.
  - Byte j of word w in cycle k+3+4w+j (j=0 is bits 31:24).
  - 0xFF in cycle k+3+4N.
  - `done_o` in cycle k+4+4N.
- Stream length is 4N+2 contiguous valid cycles. A bubble would corrupt the receiver's byte count.
- Source RAM timing: exactly 1 cycle read latency. `rd_data_i` is consumed only in the cycle after `rd_en_o`.
- The earliest back-to-back restart is `start_i` in the `done_o` cycle.

## Structure
- Shared package `instr_load_pkg`: `START_MARK`=8'hFE, `END_MARK`=8'hFF, `PAD_BYTE`=8'h00, and the FSM state enum.
- The instruction memory and this block both import the package.
- Single module; no sub-module needed.
- The serializer shift register stays inline.

## Test plan
- N=1, word 0x12345678 → bytes FE,12,34,56,78,FF in cycles k+2..k+7; `done_o` at k+8; `clip_o`=0.
- N=3 into a reference instruction memory, words 0xDEADBEEF, 0x00000013, 0xCAFEF00D → instruction memory words 0..2 match exactly; no gaps in `byte_valid_o`.
- N=0 → FE at k+2, FF at k+3, `done_o` at k+4; `rd_en_o` pulses only in FETCH.
- Word 0xFF00FEFF → payload 00,00,FE,00; `clip_o`=1 until the next start, then 0.
- `num_words_i`=100 → clamps to 64; 258 valid bytes; last `rd_addr_o`=63; `start_i` pulsed mid-stream is ignored.
- `reset` at byte 5 of N=4 → next cycle `byte_o`=0x00, `busy_o`=0; a fresh start afterwards gives a full correct stream.
